// File: rtl/reservation_station.sv
// reservation_station: issue queue feeding the ALU.
// Holds dispatched ALU/branch/JALR ops until both operands are known, snoops the ALU and
// load/store result buses to wake waiting operands, and issues at most one ready op per
// cycle as a registered req/type/r1/r2/rob_id bundle.
//
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (low = hold all state), flush (sync clear)
//   dis_*      : dispatch request, op type, dest tag, operand values/deps/producer tags
//   full       : registered, no free entry
//   alu_cdb_*  : ALU result bus          lsb_cdb_* : load/store result bus
//   alu_*      : registered issue bundle to the ALU (alu_req is a one-cycle pulse)
//
// Build option: define RS_ISSUE_OLDEST_EN to select the oldest eligible entry (by a wrapping
// dispatch sequence stamp) instead of the lowest-index eligible entry.

`ifndef TYPE_BIT
`define TYPE_BIT 5
`endif
`ifndef ROB_INDEX_BIT
`define ROB_INDEX_BIT 4
`endif

module reservation_station #(
  parameter int unsigned RS_SIZE    = 8,
  parameter int unsigned RS_IDX_BIT = 3,
  parameter int unsigned TYPE_W     = `TYPE_BIT,
  parameter int unsigned ROB_W      = `ROB_INDEX_BIT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush,
  input  logic              dis_valid,
  input  logic [TYPE_W-1:0] dis_type,
  input  logic [ROB_W-1:0]  dis_rob_id,
  input  logic [31:0]       dis_v1,
  input  logic [31:0]       dis_v2,
  input  logic              dis_dep1,
  input  logic              dis_dep2,
  input  logic [ROB_W-1:0]  dis_q1,
  input  logic [ROB_W-1:0]  dis_q2,
  output logic              full,
  input  logic              alu_cdb_valid,
  input  logic [ROB_W-1:0]  alu_cdb_rob_id,
  input  logic [31:0]       alu_cdb_value,
  input  logic              lsb_cdb_valid,
  input  logic [ROB_W-1:0]  lsb_cdb_rob_id,
  input  logic [31:0]       lsb_cdb_value,
  output logic              alu_req,
  output logic [TYPE_W-1:0] alu_type,
  output logic [31:0]       alu_r1,
  output logic [31:0]       alu_r2,
  output logic [ROB_W-1:0]  alu_rob_id
);

  logic [RS_SIZE-1:0]             busy_q, busy_d, dep1_q, dep1_d, dep2_q, dep2_d;
  logic [RS_SIZE-1:0][TYPE_W-1:0] type_q, type_d;
  logic [RS_SIZE-1:0][ROB_W-1:0]  rob_q, rob_d, q1_q, q1_d, q2_q, q2_d;
  logic [RS_SIZE-1:0][31:0]       v1_q, v1_d, v2_q, v2_d;
  logic [RS_IDX_BIT:0]            count_q, count_d;
  logic                           full_q, full_d;
  logic                           alu_req_q, alu_req_d;
  logic [TYPE_W-1:0]              alu_type_q, alu_type_d;
  logic [31:0]                    alu_r1_q, alu_r1_d, alu_r2_q, alu_r2_d;
  logic [ROB_W-1:0]               alu_rob_id_q, alu_rob_id_d;
`ifdef RS_ISSUE_OLDEST_EN
  logic [RS_SIZE-1:0][RS_IDX_BIT:0] age_q, age_d;
  logic [RS_IDX_BIT:0]              seq_q, seq_d, sel_dist, cur_dist;
`endif

  logic                  sel_found, free_found, dis_acc;
  logic [RS_IDX_BIT-1:0] sel_idx, free_idx;
  logic [31:0]           byp_v1, byp_v2;
  logic                  byp_dep1, byp_dep2;

  // Issue select and free-slot search, both over registered state only.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
`ifdef RS_ISSUE_OLDEST_EN
    sel_dist = '0;
    cur_dist = '0;
`endif
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (busy_q[i] && !dep1_q[i] && !dep2_q[i]) begin
`ifdef RS_ISSUE_OLDEST_EN
        // Distance back from the sequence counter; larger means dispatched earlier.
        cur_dist = seq_q - age_q[i];
        if (!sel_found || (cur_dist > sel_dist)) begin
          sel_found = 1'b1;
          sel_idx   = RS_IDX_BIT'(i);
          sel_dist  = cur_dist;
        end
`else
        if (!sel_found) begin
          sel_found = 1'b1;
          sel_idx   = RS_IDX_BIT'(i);
        end
`endif
      end
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = RS_IDX_BIT'(i);
      end
    end
  end

  // Dispatch bypass: capture a result broadcast in the same cycle; ALU bus wins a tie.
  always_comb begin
    byp_v1   = dis_v1;
    byp_dep1 = dis_dep1;
    byp_v2   = dis_v2;
    byp_dep2 = dis_dep2;
    if (dis_dep1 && alu_cdb_valid && (alu_cdb_rob_id == dis_q1)) begin
      byp_v1   = alu_cdb_value;
      byp_dep1 = 1'b0;
    end else if (dis_dep1 && lsb_cdb_valid && (lsb_cdb_rob_id == dis_q1)) begin
      byp_v1   = lsb_cdb_value;
      byp_dep1 = 1'b0;
    end
    if (dis_dep2 && alu_cdb_valid && (alu_cdb_rob_id == dis_q2)) begin
      byp_v2   = alu_cdb_value;
      byp_dep2 = 1'b0;
    end else if (dis_dep2 && lsb_cdb_valid && (lsb_cdb_rob_id == dis_q2)) begin
      byp_v2   = lsb_cdb_value;
      byp_dep2 = 1'b0;
    end
  end

  assign dis_acc = dis_valid && !full_q && free_found;

  always_comb begin
    busy_d       = busy_q;
    dep1_d       = dep1_q;
    dep2_d       = dep2_q;
    type_d       = type_q;
    rob_d        = rob_q;
    q1_d         = q1_q;
    q2_d         = q2_q;
    v1_d         = v1_q;
    v2_d         = v2_q;
    count_d      = count_q;
    full_d       = full_q;
    alu_req_d    = alu_req_q;
    alu_type_d   = alu_type_q;
    alu_r1_d     = alu_r1_q;
    alu_r2_d     = alu_r2_q;
    alu_rob_id_d = alu_rob_id_q;
`ifdef RS_ISSUE_OLDEST_EN
    age_d = age_q;
    seq_d = seq_q;
`endif
    if (rdy_in) begin
      if (flush) begin
        busy_d    = '0;
        count_d   = '0;
        full_d    = 1'b0;
        alu_req_d = 1'b0;
`ifdef RS_ISSUE_OLDEST_EN
        seq_d = '0;
`endif
      end else begin
        // Wakeup of waiting operands in occupied entries.
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (busy_q[i] && dep1_q[i]) begin
            if (alu_cdb_valid && (alu_cdb_rob_id == q1_q[i])) begin
              v1_d[i]   = alu_cdb_value;
              dep1_d[i] = 1'b0;
            end else if (lsb_cdb_valid && (lsb_cdb_rob_id == q1_q[i])) begin
              v1_d[i]   = lsb_cdb_value;
              dep1_d[i] = 1'b0;
            end
          end
          if (busy_q[i] && dep2_q[i]) begin
            if (alu_cdb_valid && (alu_cdb_rob_id == q2_q[i])) begin
              v2_d[i]   = alu_cdb_value;
              dep2_d[i] = 1'b0;
            end else if (lsb_cdb_valid && (lsb_cdb_rob_id == q2_q[i])) begin
              v2_d[i]   = lsb_cdb_value;
              dep2_d[i] = 1'b0;
            end
          end
        end
        // Issue.
        alu_req_d = sel_found;
        if (sel_found) begin
          busy_d[sel_idx] = 1'b0;
          alu_type_d      = type_q[sel_idx];
          alu_r1_d        = v1_q[sel_idx];
          alu_r2_d        = v2_q[sel_idx];
          alu_rob_id_d    = rob_q[sel_idx];
        end
        // Dispatch into a slot that is free in registered state.
        if (dis_acc) begin
          busy_d[free_idx] = 1'b1;
          type_d[free_idx] = dis_type;
          rob_d[free_idx]  = dis_rob_id;
          q1_d[free_idx]   = dis_q1;
          q2_d[free_idx]   = dis_q2;
          v1_d[free_idx]   = byp_v1;
          v2_d[free_idx]   = byp_v2;
          dep1_d[free_idx] = byp_dep1;
          dep2_d[free_idx] = byp_dep2;
`ifdef RS_ISSUE_OLDEST_EN
          age_d[free_idx] = seq_q;
          seq_d           = seq_q + 1'b1;
`endif
        end
        count_d = count_q + (RS_IDX_BIT+1)'(dis_acc) - (RS_IDX_BIT+1)'(sel_found);
        full_d  = (count_d == (RS_IDX_BIT+1)'(RS_SIZE));
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q       <= '0;
      dep1_q       <= '0;
      dep2_q       <= '0;
      type_q       <= '0;
      rob_q        <= '0;
      q1_q         <= '0;
      q2_q         <= '0;
      v1_q         <= '0;
      v2_q         <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      alu_req_q    <= 1'b0;
      alu_type_q   <= '0;
      alu_r1_q     <= '0;
      alu_r2_q     <= '0;
      alu_rob_id_q <= '0;
`ifdef RS_ISSUE_OLDEST_EN
      age_q <= '0;
      seq_q <= '0;
`endif
    end else begin
      busy_q       <= busy_d;
      dep1_q       <= dep1_d;
      dep2_q       <= dep2_d;
      type_q       <= type_d;
      rob_q        <= rob_d;
      q1_q         <= q1_d;
      q2_q         <= q2_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      count_q      <= count_d;
      full_q       <= full_d;
      alu_req_q    <= alu_req_d;
      alu_type_q   <= alu_type_d;
      alu_r1_q     <= alu_r1_d;
      alu_r2_q     <= alu_r2_d;
      alu_rob_id_q <= alu_rob_id_d;
`ifdef RS_ISSUE_OLDEST_EN
      age_q <= age_d;
      seq_q <= seq_d;
`endif
    end
  end

  assign full       = full_q;
  assign alu_req    = alu_req_q;
  assign alu_type   = alu_type_q;
  assign alu_r1     = alu_r1_q;
  assign alu_r2     = alu_r2_q;
  assign alu_rob_id = alu_rob_id_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station (TYPE_W=5, ROB_W=4, RS_SIZE=8).
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_reservation_station;

  logic        clk_in, rst_in, rdy_in, flush;
  logic        dis_valid, dis_dep1, dis_dep2;
  logic [4:0]  dis_type;
  logic [3:0]  dis_rob_id, dis_q1, dis_q2;
  logic [31:0] dis_v1, dis_v2;
  logic        full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_rob_id, lsb_cdb_rob_id;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  logic        alu_req;
  logic [4:0]  alu_type;
  logic [31:0] alu_r1, alu_r2;
  logic [3:0]  alu_rob_id;
  logic [73:0] obs;

  int vecs = 0;
  int errs = 0;

  assign obs = {alu_req, alu_type, alu_rob_id, alu_r1, alu_r2};

  reservation_station #(
    .RS_SIZE(8), .RS_IDX_BIT(3), .TYPE_W(5), .ROB_W(4)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .dis_valid(dis_valid), .dis_type(dis_type), .dis_rob_id(dis_rob_id),
    .dis_v1(dis_v1), .dis_v2(dis_v2), .dis_dep1(dis_dep1), .dis_dep2(dis_dep2),
    .dis_q1(dis_q1), .dis_q2(dis_q2), .full(full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id),
    .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id),
    .lsb_cdb_value(lsb_cdb_value),
    .alu_req(alu_req), .alu_type(alu_type), .alu_r1(alu_r1), .alu_r2(alu_r2),
    .alu_rob_id(alu_rob_id)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    dis_valid     = 1'b0;
    dis_dep1      = 1'b0;
    dis_dep2      = 1'b0;
    alu_cdb_valid = 1'b0;
    lsb_cdb_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic drive_dis(input logic [4:0] t, input logic [3:0] rob, input logic [31:0] v1,
                           input logic [31:0] v2, input logic d1, input logic [3:0] q1,
                           input logic d2, input logic [3:0] q2);
    dis_valid  = 1'b1;
    dis_type   = t;
    dis_rob_id = rob;
    dis_v1     = v1;
    dis_v2     = v2;
    dis_dep1   = d1;
    dis_q1     = q1;
    dis_dep2   = d2;
    dis_q2     = q2;
  endtask

  task automatic cdb_alu(input logic [3:0] tag, input logic [31:0] val);
    alu_cdb_valid  = 1'b1;
    alu_cdb_rob_id = tag;
    alu_cdb_value  = val;
  endtask

  task automatic cdb_lsb(input logic [3:0] tag, input logic [31:0] val);
    lsb_cdb_valid  = 1'b1;
    lsb_cdb_rob_id = tag;
    lsb_cdb_value  = val;
  endtask

  task automatic test_reset();
    #3;
    vecs++;
    if ({obs, full} !== 75'd0) begin
      errs++;
      $display("FAIL reset_state: got %h want 0", {obs, full});
    end
    tick();
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_add();
    drive_dis(5'd1, 4'd2, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
    vecs++;
    if (alu_req !== 1'b0) begin
      errs++;
      $display("FAIL add_no_early_req: got %b want 0", alu_req);
    end
    tick();
    vecs++;
    if (obs !== {1'b1, 5'd1, 4'd2, 32'd5, 32'd7}) begin
      errs++;
      $display("FAIL add_issue: got %h want %h", obs, {1'b1, 5'd1, 4'd2, 32'd5, 32'd7});
    end
    tick();
    vecs++;
    if (alu_req !== 1'b0) begin
      errs++;
      $display("FAIL add_pulse_end: got %b want 0", alu_req);
    end
  endtask

  task automatic test_wakeup();
    // ALU bus wakeup of operand 1.
    drive_dis(5'd2, 4'd5, 32'd0, 32'd1, 1'b1, 4'd3, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    vecs++;
    if (alu_req !== 1'b0) begin
      errs++;
      $display("FAIL alu_wait_no_issue: got %b want 0", alu_req);
    end
    cdb_alu(4'd3, 32'h10);
    tick();
    idle();
    vecs++;
    if (alu_req !== 1'b0) begin
      errs++;
      $display("FAIL alu_wake_same_cycle: got %b want 0", alu_req);
    end
    tick();
    vecs++;
    if (obs !== {1'b1, 5'd2, 4'd5, 32'h10, 32'd1}) begin
      errs++;
      $display("FAIL alu_wake_issue: got %h want %h", obs, {1'b1, 5'd2, 4'd5, 32'h10, 32'd1});
    end
    tick();
    // Load/store bus wakeup of operand 1.
    drive_dis(5'd2, 4'd6, 32'd0, 32'd2, 1'b1, 4'd7, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    vecs++;
    if (alu_req !== 1'b0) begin
      errs++;
      $display("FAIL lsb_wait_no_issue: got %b want 0", alu_req);
    end
    cdb_lsb(4'd7, 32'h20);
    tick();
    idle();
    tick();
    vecs++;
    if (obs !== {1'b1, 5'd2, 4'd6, 32'h20, 32'd2}) begin
      errs++;
      $display("FAIL lsb_wake_issue: got %h want %h", obs, {1'b1, 5'd2, 4'd6, 32'h20, 32'd2});
    end
    tick();
    // Both buses carry the same tag: ALU value wins.
    drive_dis(5'd3, 4'd6, 32'd0, 32'd2, 1'b1, 4'd10, 1'b0, 4'd0);
    tick();
    idle();
    cdb_alu(4'd10, 32'h111);
    cdb_lsb(4'd10, 32'h222);
    tick();
    idle();
    tick();
    vecs++;
    if (obs !== {1'b1, 5'd3, 4'd6, 32'h111, 32'd2}) begin
      errs++;
      $display("FAIL cdb_tie: got %h want %h", obs, {1'b1, 5'd3, 4'd6, 32'h111, 32'd2});
    end
    tick();
  endtask

  task automatic test_bypass();
    drive_dis(5'd4, 4'd8, 32'd9, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4);
    cdb_lsb(4'd4, 32'hABCD);
    tick();
    idle();
    tick();
    vecs++;
    if (obs !== {1'b1, 5'd4, 4'd8, 32'd9, 32'hABCD}) begin
      errs++;
      $display("FAIL bypass_issue: got %h want %h", obs, {1'b1, 5'd4, 4'd8, 32'd9, 32'hABCD});
    end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      drive_dis(5'd1, 4'(i), 32'd0, 32'(i), 1'b1, 4'(8 + i), 1'b0, 4'd0);
      tick();
      if (i == 6) begin
        vecs++;
        if (full !== 1'b0) begin
          errs++;
          $display("FAIL full_at_7: got %b want 0", full);
        end
      end
    end
    vecs++;
    if (full !== 1'b1) begin
      errs++;
      $display("FAIL full_at_8: got %b want 1", full);
    end
    // Ninth request is ready and would issue if it had been accepted.
    drive_dis(5'd6, 4'd12, 32'h99, 32'h99, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    vecs++;
    if ({full, alu_req} !== 2'b10) begin
      errs++;
      $display("FAIL ninth_ignored: got %b want 10", {full, alu_req});
    end
    cdb_alu(4'd11, 32'h33);
    tick();
    idle();
    vecs++;
    if ({full, alu_req} !== 2'b10) begin
      errs++;
      $display("FAIL full_wake_hold: got %b want 10", {full, alu_req});
    end
    tick();
    vecs++;
    if ({full, obs} !== {1'b0, 1'b1, 5'd1, 4'd3, 32'h33, 32'd3}) begin
      errs++;
      $display("FAIL full_free_issue: got %h want %h", {full, obs},
               {1'b0, 1'b1, 5'd1, 4'd3, 32'h33, 32'd3});
    end
    // Dispatch into the freed slot while entry 5 issues: count stays at 7.
    cdb_alu(4'd13, 32'h55);
    tick();
    idle();
    drive_dis(5'd2, 4'd3, 32'd0, 32'h77, 1'b1, 4'd11, 1'b0, 4'd0);
    tick();
    idle();
    vecs++;
    if ({full, obs} !== {1'b0, 1'b1, 5'd1, 4'd5, 32'h55, 32'd5}) begin
      errs++;
      $display("FAIL disp_and_issue: got %h want %h", {full, obs},
               {1'b0, 1'b1, 5'd1, 4'd5, 32'h55, 32'd5});
    end
    drive_dis(5'd2, 4'd5, 32'd0, 32'h78, 1'b1, 4'd11, 1'b0, 4'd0);
    tick();
    idle();
    vecs++;
    if (full !== 1'b1) begin
      errs++;
      $display("FAIL refill_full: got %b want 1", full);
    end
  endtask

  task automatic test_flush();
    // Entry 0 becomes eligible exactly when flush arrives, with a ready dispatch alongside.
    cdb_alu(4'd8, 32'h1);
    tick();
    idle();
    flush = 1'b1;
    drive_dis(5'd7, 4'd9, 32'h1, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
    vecs++;
    if ({full, alu_req} !== 2'b00) begin
      errs++;
      $display("FAIL flush_clear: got %b want 00", {full, alu_req});
    end
    cdb_alu(4'd11, 32'h5);
    for (int i = 0; i < 3; i++) begin
      tick();
      idle();
      vecs++;
      if (alu_req !== 1'b0) begin
        errs++;
        $display("FAIL flush_no_issue: got %b want 0 (cycle %0d)", alu_req, i);
      end
    end
  endtask

  task automatic test_rdy_hold();
    drive_dis(5'd5, 4'd1, 32'h55, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
    rdy_in = 1'b0;
    drive_dis(5'd5, 4'd2, 32'hEE, 32'hEE, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (alu_req !== 1'b0) begin
        errs++;
        $display("FAIL rdy_low_hold0: got %b want 0 (cycle %0d)", alu_req, i);
      end
    end
    idle();
    rdy_in = 1'b1;
    tick();
    vecs++;
    if (obs !== {1'b1, 5'd5, 4'd1, 32'h55, 32'h66}) begin
      errs++;
      $display("FAIL rdy_resume: got %h want %h", obs, {1'b1, 5'd5, 4'd1, 32'h55, 32'h66});
    end
    rdy_in = 1'b0;
    tick();
    vecs++;
    if (obs !== {1'b1, 5'd5, 4'd1, 32'h55, 32'h66}) begin
      errs++;
      $display("FAIL rdy_low_hold1: got %h want %h", obs, {1'b1, 5'd5, 4'd1, 32'h55, 32'h66});
    end
    rdy_in = 1'b1;
    tick();
    vecs++;
    if (alu_req !== 1'b0) begin
      errs++;
      $display("FAIL rdy_dis_ignored: got %b want 0", alu_req);
    end
  endtask

  task automatic test_select_order();
    logic [73:0] first_exp, second_exp;
    for (int i = 0; i < 6; i++) begin
      drive_dis(5'd1, 4'(i), 32'd0, 32'(i), 1'b1, 4'(8 + i), 1'b0, 4'd0);
      tick();
    end
    idle();
    cdb_alu(4'd9, 32'd9);
    tick();
    idle();
    tick();
    vecs++;
    if (obs !== {1'b1, 5'd1, 4'd1, 32'd9, 32'd1}) begin
      errs++;
      $display("FAIL order_first_wake: got %h want %h", obs, {1'b1, 5'd1, 4'd1, 32'd9, 32'd1});
    end
    // Wake old entry 5 while a younger ready op lands in freed entry 1.
    cdb_alu(4'd13, 32'd5);
    drive_dis(5'd2, 4'd1, 32'hA1, 32'hB1, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
`ifdef RS_ISSUE_OLDEST_EN
    first_exp  = {1'b1, 5'd1, 4'd5, 32'd5, 32'd5};
    second_exp = {1'b1, 5'd2, 4'd1, 32'hA1, 32'hB1};
`else
    first_exp  = {1'b1, 5'd2, 4'd1, 32'hA1, 32'hB1};
    second_exp = {1'b1, 5'd1, 4'd5, 32'd5, 32'd5};
`endif
    tick();
    vecs++;
    if (obs !== first_exp) begin
      errs++;
      $display("FAIL order_first: got %h want %h", obs, first_exp);
    end
    tick();
    vecs++;
    if (obs !== second_exp) begin
      errs++;
      $display("FAIL order_second: got %h want %h", obs, second_exp);
    end
    flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_async_reset();
    drive_dis(5'd3, 4'd7, 32'h70, 32'h71, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    vecs++;
    if (obs !== {1'b1, 5'd3, 4'd7, 32'h70, 32'h71}) begin
      errs++;
      $display("FAIL pre_reset_issue: got %h want %h", obs, {1'b1, 5'd3, 4'd7, 32'h70, 32'h71});
    end
    #2;
    rst_in = 1'b0;
    #1;
    vecs++;
    if ({obs, full} !== 75'd0) begin
      errs++;
      $display("FAIL async_reset: got %h want 0", {obs, full});
    end
    tick();
    rst_in = 1'b1;
    drive_dis(5'd4, 4'd2, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    vecs++;
    if (obs !== {1'b1, 5'd4, 4'd2, 32'd3, 32'd4}) begin
      errs++;
      $display("FAIL post_reset_issue: got %h want %h", obs, {1'b1, 5'd4, 4'd2, 32'd3, 32'd4});
    end
  endtask

  initial begin
    rst_in         = 1'b0;
    rdy_in         = 1'b1;
    dis_type       = '0;
    dis_rob_id     = '0;
    dis_v1         = '0;
    dis_v2         = '0;
    dis_q1         = '0;
    dis_q2         = '0;
    alu_cdb_rob_id = '0;
    alu_cdb_value  = '0;
    lsb_cdb_rob_id = '0;
    lsb_cdb_value  = '0;
    idle();
    test_reset();
    test_add();
    test_wakeup();
    test_bypass();
    test_full();
    test_flush();
    test_rdy_hold();
    test_select_order();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
